// File: rtl/sd_sector_responder.sv
// sd_sector_responder: target-side servicer for the virtual-disk sector protocol.
// Arbitrates per-drive sd_rd/sd_wr requests (lowest index wins), acknowledges the
// winner, and moves one 512-byte sector between the initiator buffer and a
// byte-wide backing store. Also keeps a per-drive mount table and publishes
// mount events on img_mounted/img_size/img_readonly.
// Optional feature macro: SD_RESPONDER_WRITE_EN enables the memory write path;
// without it every write is acknowledged as a null transfer and mem_we stays 0.
module sd_sector_responder #(
    parameter int NUM_DRIVES = 3,
    parameter int ADDR_W     = 41
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [32*NUM_DRIVES-1:0] sd_lba_flat,
    input  logic [NUM_DRIVES-1:0]    sd_rd,
    input  logic [NUM_DRIVES-1:0]    sd_wr,
    output logic [NUM_DRIVES-1:0]    sd_ack,
    output logic [8:0]               sd_buff_addr,
    output logic [7:0]               sd_buff_dout,
    output logic                     sd_buff_wr,
    input  logic [8*NUM_DRIVES-1:0]  sd_buff_din_flat,
    output logic [NUM_DRIVES-1:0]    img_mounted,
    output logic [63:0]              img_size,
    output logic                     img_readonly,
    input  logic                     mount_req,
    input  logic [1:0]               mount_drive,
    input  logic [63:0]              mount_size,
    input  logic                     mount_ro,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [1:0]               mem_drive,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [7:0]               mem_wdata,
    input  logic [7:0]               mem_rdata,
    input  logic                     mem_ack,
    output logic                     xfer_err
);

`ifdef SD_RESPONDER_WRITE_EN
    localparam bit WRITE_EN = 1'b1;
`else
    localparam bit WRITE_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_GRANT, S_RD_REQ, S_RD_PUT, S_WR_ADDR, S_WR_SAMPLE, S_WR_REQ, S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              drive_q, drive_d;
    logic [31:0]             lba_q, lba_d;
    logic                    is_wr_q, is_wr_d;
    logic                    null_q, null_d;
    logic [8:0]              off_q, off_d;
    logic [NUM_DRIVES-1:0]   ack_q, ack_d;
    logic [8:0]              buff_addr_q, buff_addr_d;
    logic [7:0]              buff_dout_q, buff_dout_d;
    logic                    buff_wr_q, buff_wr_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
    logic [7:0]              mem_wdata_q, mem_wdata_d;
    logic                    err_q, err_d;
    logic [NUM_DRIVES-1:0]   mounted_q, mounted_d;
    logic [63:0]             img_size_q, img_size_d;
    logic                    img_ro_q, img_ro_d;
    logic [63:0]             size_tab_q [NUM_DRIVES];
    logic [63:0]             size_tab_d [NUM_DRIVES];
    logic                    ro_tab_q   [NUM_DRIVES];
    logic                    ro_tab_d   [NUM_DRIVES];

    logic [31:0]             lba_arr [NUM_DRIVES];
    logic [7:0]              din_arr [NUM_DRIVES];
    logic [1:0]              win;
    logic                    req_any;
    logic [63:0]             win_end;
    logic [ADDR_W-1:0]       base_addr;
    logic [8:0]              off_inc;

    // Split the flattened per-drive buses into indexable arrays
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DRIVES; gi++) begin : g_unpack
            assign lba_arr[gi] = sd_lba_flat[32*gi +: 32];
            assign din_arr[gi] = sd_buff_din_flat[8*gi +: 8];
        end
    endgenerate

    // Sector end byte of the candidate winner, and the latched sector base address
    assign win_end   = {23'd0, lba_arr[win], 9'd0} + 64'd512;
    assign base_addr = ADDR_W'({lba_q, 9'd0});
    assign off_inc   = off_q + 9'd1;

    // Fixed-priority arbitration: lowest-index requesting drive wins
    always_comb begin
        win     = 2'd0;
        req_any = 1'b0;
        for (int i = NUM_DRIVES - 1; i >= 0; i--) begin
            if (sd_rd[i] || sd_wr[i]) begin
                win     = 2'(i);
                req_any = 1'b1;
            end
        end
    end

    // Next-state and next-output logic for the transfer FSM and the mount table
    always_comb begin
        state_d     = state_q;
        drive_d     = drive_q;
        lba_d       = lba_q;
        is_wr_d     = is_wr_q;
        null_d      = null_q;
        off_d       = off_q;
        ack_d       = ack_q;
        buff_addr_d = buff_addr_q;
        buff_dout_d = buff_dout_q;
        buff_wr_d   = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = 1'b0;
        mounted_d   = '0;
        img_size_d  = img_size_q;
        img_ro_d    = img_ro_q;
        size_tab_d  = size_tab_q;
        ro_tab_d    = ro_tab_q;

        // Mount updates the table only; an in-flight transfer keeps its latched null flag
        if (mount_req && (int'(mount_drive) < NUM_DRIVES)) begin
            size_tab_d[mount_drive] = mount_size;
            ro_tab_d[mount_drive]   = mount_ro;
            mounted_d[mount_drive]  = 1'b1;
            img_size_d              = mount_size;
            img_ro_d                = mount_ro;
        end

        case (state_q)
            S_IDLE: begin
                ack_d = '0;
                if (req_any) begin
                    drive_d = win;
                    lba_d   = lba_arr[win];
                    // Read wins when both directions are requested at once
                    is_wr_d = !sd_rd[win];
                    err_d   = sd_rd[win] && sd_wr[win];
                    null_d  = (size_tab_q[win] == 64'd0) || (win_end > size_tab_q[win]) ||
                              (!sd_rd[win] && (ro_tab_q[win] || !WRITE_EN));
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                ack_d          = '0;
                ack_d[drive_q] = 1'b1;
                off_d          = 9'd0;
                err_d          = null_q;
                if (!is_wr_q) begin
                    state_d = S_RD_REQ;
                    if (!null_q) begin
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = base_addr;
                    end
                end else begin
                    // Present offset 0 now so buffer data is ready in WR_SAMPLE
                    buff_addr_d = 9'd0;
                    state_d     = S_WR_ADDR;
                end
            end
            S_RD_REQ: begin
                if (null_q) begin
                    buff_dout_d = 8'h00;
                    state_d     = S_RD_PUT;
                end else if (mem_req_q && mem_ack) begin
                    buff_dout_d = mem_rdata;
                    mem_req_d   = 1'b0;
                    state_d     = S_RD_PUT;
                end
            end
            S_RD_PUT: begin
                buff_wr_d   = 1'b1;
                buff_addr_d = off_q;
                if (off_q == 9'd511) begin
                    state_d = S_DONE;
                end else begin
                    off_d   = off_inc;
                    state_d = S_RD_REQ;
                    if (!null_q) begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = base_addr + ADDR_W'(off_inc);
                    end
                end
            end
            S_WR_ADDR: begin
                state_d = S_WR_SAMPLE;
            end
            S_WR_SAMPLE: begin
                mem_wdata_d = din_arr[drive_q];
                state_d     = S_WR_REQ;
                if (!null_q) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = WRITE_EN;
                    mem_addr_d = base_addr + ADDR_W'(off_q);
                end
            end
            S_WR_REQ: begin
                if (null_q || (mem_req_q && mem_ack)) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (off_q == 9'd511) begin
                        state_d = S_DONE;
                    end else begin
                        off_d       = off_inc;
                        buff_addr_d = off_inc;
                        state_d     = S_WR_ADDR;
                    end
                end
            end
            S_DONE: begin
                ack_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                ack_d     = '0;
                mem_req_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // All state and registered outputs; reset abandons any partial sector
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            drive_q     <= 2'd0;
            lba_q       <= 32'd0;
            is_wr_q     <= 1'b0;
            null_q      <= 1'b0;
            off_q       <= 9'd0;
            ack_q       <= '0;
            buff_addr_q <= 9'd0;
            buff_dout_q <= 8'd0;
            buff_wr_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'd0;
            err_q       <= 1'b0;
            mounted_q   <= '0;
            img_size_q  <= 64'd0;
            img_ro_q    <= 1'b0;
            for (int i = 0; i < NUM_DRIVES; i++) begin
                size_tab_q[i] <= 64'd0;
                ro_tab_q[i]   <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            drive_q     <= drive_d;
            lba_q       <= lba_d;
            is_wr_q     <= is_wr_d;
            null_q      <= null_d;
            off_q       <= off_d;
            ack_q       <= ack_d;
            buff_addr_q <= buff_addr_d;
            buff_dout_q <= buff_dout_d;
            buff_wr_q   <= buff_wr_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
            mounted_q   <= mounted_d;
            img_size_q  <= img_size_d;
            img_ro_q    <= img_ro_d;
            size_tab_q  <= size_tab_d;
            ro_tab_q    <= ro_tab_d;
        end
    end

    assign sd_ack       = ack_q;
    assign sd_buff_addr = buff_addr_q;
    assign sd_buff_dout = buff_dout_q;
    assign sd_buff_wr   = buff_wr_q;
    assign img_mounted  = mounted_q;
    assign img_size     = img_size_q;
    assign img_readonly = img_ro_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_drive    = drive_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign xfer_err     = err_q;

endmodule

// File: tb/tb_sd_sector_responder.sv
// Scoreboard bench for sd_sector_responder: stimulus pushes expected buffer
// writes, memory requests and mount pulses into queues; a negedge monitor pops
// and compares them as the DUT presents them.
module tb_sd_sector_responder;
    localparam int ND = 3;
    localparam int AW = 41;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [31:0]     lba [ND];
    logic [32*ND-1:0] sd_lba_flat;
    logic [ND-1:0]   sd_rd = '0;
    logic [ND-1:0]   sd_wr = '0;
    logic [ND-1:0]   sd_ack;
    logic [8:0]      sd_buff_addr;
    logic [7:0]      sd_buff_dout;
    logic            sd_buff_wr;
    logic [8*ND-1:0] sd_buff_din_flat;
    logic [ND-1:0]   img_mounted;
    logic [63:0]     img_size;
    logic            img_readonly;
    logic            mount_req = 1'b0;
    logic [1:0]      mount_drive = 2'd0;
    logic [63:0]     mount_size = 64'd0;
    logic            mount_ro = 1'b0;
    logic            mem_req;
    logic            mem_we;
    logic [1:0]      mem_drive;
    logic [AW-1:0]   mem_addr;
    logic [7:0]      mem_wdata;
    logic [7:0]      mem_rdata;
    logic            mem_ack;
    logic            xfer_err;

    always #5 clk = ~clk;

    sd_sector_responder #(.NUM_DRIVES(ND), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .sd_lba_flat(sd_lba_flat), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
        .sd_buff_din_flat(sd_buff_din_flat),
        .img_mounted(img_mounted), .img_size(img_size), .img_readonly(img_readonly),
        .mount_req(mount_req), .mount_drive(mount_drive), .mount_size(mount_size), .mount_ro(mount_ro),
        .mem_req(mem_req), .mem_we(mem_we), .mem_drive(mem_drive), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .xfer_err(xfer_err)
    );

    assign sd_lba_flat = {lba[2], lba[1], lba[0]};

    // Initiator buffer with 1-cycle registered read; each drive sees a distinct pattern
    logic [7:0] host_buf [512];
    logic [7:0] din_q;
    always @(posedge clk) din_q <= host_buf[sd_buff_addr];
    assign sd_buff_din_flat = {din_q ^ 8'h22, din_q ^ 8'h11, din_q};

    function automatic logic [7:0] mem_fn(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    // Backing store: one-cycle ack, data from a fixed address function
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_ack   <= 1'b0;
            mem_rdata <= 8'd0;
        end else begin
            mem_ack   <= mem_req && !mem_ack;
            mem_rdata <= mem_fn(mem_addr);
        end
    end

    typedef struct { logic [1:0] drive; logic [8:0] addr; logic [7:0] data; } buf_ev_t;
    typedef struct { logic [1:0] drive; logic [AW-1:0] addr; logic we; logic [7:0] wdata; } mem_ev_t;
    typedef struct { logic [2:0] mask; logic [63:0] size; logic ro; } mnt_ev_t;

    buf_ev_t exp_buf [$];
    mem_ev_t exp_mem [$];
    mnt_ev_t exp_mnt [$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int err_cnt = 0;
    int onehot_viol = 0;
    int last_wr_cyc = 0;
    int ack_rise [ND];
    int ack_fall [ND];
    logic [ND-1:0] ack_prev = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops expectations whenever the DUT presents an output event
    always @(negedge clk) begin
        buf_ev_t be;
        mem_ev_t me;
        mnt_ev_t ne;
        if (!reset) begin
            if (sd_buff_wr) begin
                last_wr_cyc = cyc;
                if (exp_buf.size() == 0) check("buf_wr_unexpected", 64'(sd_buff_addr) | 64'h1000, 64'h0);
                else begin
                    be = exp_buf.pop_front();
                    check("buf_addr", 64'(sd_buff_addr), 64'(be.addr));
                    check("buf_data", 64'(sd_buff_dout), 64'(be.data));
                    check("buf_ack", 64'(sd_ack), 64'(3'b001 << be.drive));
                end
                $display("buf_wr drive_ack=%b addr=%0d data=0x%02h", sd_ack, sd_buff_addr, sd_buff_dout);
            end
            if (mem_req && mem_ack) begin
                if (exp_mem.size() == 0) check("mem_unexpected", 64'(mem_addr) | (64'h1 << 60), 64'h0);
                else begin
                    me = exp_mem.pop_front();
                    check("mem_addr", 64'(mem_addr), 64'(me.addr));
                    check("mem_we", 64'(mem_we), 64'(me.we));
                    check("mem_drive", 64'(mem_drive), 64'(me.drive));
                    if (me.we) check("mem_wdata", 64'(mem_wdata), 64'(me.wdata));
                end
                $display("mem drive=%0d we=%0d addr=%0d wdata=0x%02h", mem_drive, mem_we, mem_addr, mem_wdata);
            end
            if (img_mounted != '0) begin
                if (exp_mnt.size() == 0) check("mount_unexpected", 64'(img_mounted), 64'h0);
                else begin
                    ne = exp_mnt.pop_front();
                    check("mount_mask", 64'(img_mounted), 64'(ne.mask));
                    check("mount_size", img_size, ne.size);
                    check("mount_ro", 64'(img_readonly), 64'(ne.ro));
                end
                $display("mount mask=%b size=%0d ro=%0d", img_mounted, img_size, img_readonly);
            end
            if (xfer_err) err_cnt++;
            if ($countones(sd_ack) > 1) onehot_viol++;
            for (int d = 0; d < ND; d++) begin
                if (sd_ack[d] && !ack_prev[d]) ack_rise[d] = cyc;
                if (!sd_ack[d] && ack_prev[d]) ack_fall[d] = cyc;
            end
        end
        ack_prev = sd_ack;
    end

    task automatic do_mount(input int d, input logic [63:0] size, input logic ro, input bit expect_pulse);
        mnt_ev_t ne;
        if (expect_pulse) begin
            ne.mask = 3'b001 << d;
            ne.size = size;
            ne.ro   = ro;
            exp_mnt.push_back(ne);
        end
        mount_req   = 1'b1;
        mount_drive = 2'(d);
        mount_size  = size;
        mount_ro    = ro;
        @(negedge clk);
        mount_req = 1'b0;
        repeat (3) @(negedge clk);
        check("mount_drained", 64'(exp_mnt.size()), 64'd0);
    endtask

    task automatic push_read(input int d, input logic [31:0] l, input bit null_x);
        buf_ev_t be;
        mem_ev_t me;
        for (int i = 0; i < 512; i++) begin
            me.drive = 2'(d);
            me.addr  = AW'({l, 9'd0}) + AW'(i);
            me.we    = 1'b0;
            me.wdata = 8'h00;
            if (!null_x) exp_mem.push_back(me);
            be.drive = 2'(d);
            be.addr  = 9'(i);
            be.data  = null_x ? 8'h00 : mem_fn(me.addr);
            exp_buf.push_back(be);
        end
    endtask

    task automatic push_write(input int d, input logic [31:0] l);
        mem_ev_t me;
        for (int i = 0; i < 512; i++) begin
            me.drive = 2'(d);
            me.addr  = AW'({l, 9'd0}) + AW'(i);
            me.we    = 1'b1;
            me.wdata = host_buf[i] ^ (8'(d) * 8'h11);
            exp_mem.push_back(me);
        end
    endtask

    // Raise requests; the initiator drops each drive's request when its ack rises
    task automatic run_req(input logic [2:0] rd, input logic [2:0] wr, input int exp_err);
        int lat;
        int err0;
        bit done;
        logic [2:0] seen;
        lat  = -1;
        done = 1'b0;
        seen = '0;
        err0 = err_cnt;
        sd_rd = rd;
        sd_wr = wr;
        for (int t = 1; t <= 20000; t++) begin
            @(negedge clk);
            if (sd_ack != '0 && lat < 0) lat = t;
            for (int d = 0; d < ND; d++) begin
                if (sd_ack[d]) begin
                    sd_rd[d] = 1'b0;
                    sd_wr[d] = 1'b0;
                    seen[d]  = 1'b1;
                end
            end
            if (seen == (rd | wr) && sd_ack == '0) begin
                done = 1'b1;
                break;
            end
        end
        sd_rd = '0;
        sd_wr = '0;
        repeat (2) @(negedge clk);
        check("req_done", 64'(done), 64'd1);
        check("ack_latency", 64'(lat), 64'd2);
        check("buf_queue_empty", 64'(exp_buf.size()), 64'd0);
        check("mem_queue_empty", 64'(exp_mem.size()), 64'd0);
        check("xfer_err_pulses", 64'(err_cnt - err0), 64'(exp_err));
        $display("request rd=%b wr=%b latency=%0d err_pulses=%0d", rd, wr, lat, err_cnt - err0);
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 512; i++) host_buf[i] = 8'(i) ^ 8'hA5;
        for (int d = 0; d < ND; d++) begin
            lba[d] = 32'd0;
            ack_rise[d] = 0;
            ack_fall[d] = 0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ack", 64'(sd_ack), 64'd0);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_buff_wr", 64'(sd_buff_wr), 64'd0);
        check("rst_mounted", 64'(img_mounted), 64'd0);
        check("rst_img_size", img_size, 64'd0);
        check("rst_xfer_err", 64'(xfer_err), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);

        // Mount drive 1 (1024 bytes), then an out-of-range mount that must be ignored
        do_mount(1, 64'd1024, 1'b0, 1'b1);
        do_mount(3, 64'd4096, 1'b1, 1'b0);
        check("img_size_held", img_size, 64'd1024);

        // Read drive 1, lba 1: last sector that fits exactly
        lba[1] = 32'd1;
        push_read(1, 32'd1, 1'b0);
        run_req(3'b010, 3'b000, 0);
        check("ack1_falls_after_last_wr", 64'(ack_fall[1] > last_wr_cyc), 64'd1);

        // Write drive 0, lba 0, buffer holds offset^A5
        do_mount(0, 64'd4096, 1'b0, 1'b1);
        lba[0] = 32'd0;
`ifdef SD_RESPONDER_WRITE_EN
        push_write(0, 32'd0);
        run_req(3'b000, 3'b001, 0);
`else
        run_req(3'b000, 3'b001, 1);
`endif

        // Drives 0 and 2 together: drive 0 first; drive 2 unmounted gives a zero-filled null read
        lba[0] = 32'd3;
        lba[2] = 32'd0;
        push_read(0, 32'd3, 1'b0);
        push_read(2, 32'd0, 1'b1);
        run_req(3'b101, 3'b000, 1);
        check("drive2_after_drive0", 64'(ack_rise[2] > ack_fall[0]), 64'd1);

        // Read and write together on drive 1: read serviced, error pulse
        lba[1] = 32'd0;
        push_read(1, 32'd0, 1'b0);
        run_req(3'b010, 3'b010, 1);

        // Write to a read-only drive
        do_mount(2, 64'd4096, 1'b1, 1'b1);
        run_req(3'b000, 3'b100, 1);

        // lba 2 on a 1024-byte image: write and read both null
        lba[1] = 32'd2;
        run_req(3'b000, 3'b010, 1);
        push_read(1, 32'd2, 1'b1);
        run_req(3'b010, 3'b000, 1);

        // Reset at byte 100 of a read, then a fresh read restarts at offset 0
        lba[1] = 32'd0;
        push_read(1, 32'd0, 1'b0);
        sd_rd = 3'b010;
        found = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (sd_ack[1]) sd_rd[1] = 1'b0;
            if (sd_buff_wr && sd_buff_addr == 9'd100) begin
                found = 1'b1;
                break;
            end
        end
        check("reached_byte100", 64'(found), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("midrst_ack", 64'(sd_ack), 64'd0);
        check("midrst_mem_req", 64'(mem_req), 64'd0);
        check("midrst_buff_wr", 64'(sd_buff_wr), 64'd0);
        sd_rd = '0;
        exp_buf.delete();
        exp_mem.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_img_size", img_size, 64'd0);
        do_mount(1, 64'd1024, 1'b0, 1'b1);
        push_read(1, 32'd0, 1'b0);
        run_req(3'b010, 3'b000, 0);

        check("ack_onehot_violations", 64'(onehot_viol), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #3000000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
